// File: rtl/normshift_pkg.sv
// rtl/normshift_pkg.sv - shared nonlin types and defaults for the sign normaliser
package normshift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } ns_state_e;

    localparam int NS_WIDTH = 64;
    localparam int NS_STEP  = 8;

    function automatic int ns_cw(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/normshift_lsc.sv
// rtl/normshift_lsc.sv - leading-sign counter over the top STEP+1 bits, unclamped
module normshift_lsc #(
    parameter int STEP = 8,
    parameter int RW   = $clog2(STEP + 1)
) (
    input  logic [STEP:0]   top_i,
    output logic [RW-1:0]   r_o
);

    logic run;

    always_comb begin
        r_o = '0;
        run = 1'b1;
        for (int i = STEP - 1; i >= 0; i--) begin
            if (run && (top_i[i] == top_i[STEP])) begin
                r_o = r_o + RW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/normshift.sv
// rtl/normshift.sv - iterative sign normaliser, at most STEP bits of left shift per cycle
module normshift
    import normshift_pkg::*;
#(
    parameter int WIDTH = NS_WIDTH,
    parameter int STEP  = NS_STEP,
    parameter int CW    = ns_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             normshift_i_valid,
    output logic             normshift_i_ready,
    input  logic [WIDTH-1:0] normshift_i,
    output logic             normshift_o_valid,
    input  logic             normshift_o_ready,
    output logic [WIDTH-1:0] normshift_o,
    output logic [CW-1:0]    normshift_cnt,
    output logic             normshift_zero
);

    localparam int RW = $clog2(STEP + 1);

    ns_state_e        state_q;
    logic [WIDTH-1:0] work_q;
    logic [CW-1:0]    cnt_q;
    logic             zero_q;
    logic             first_q;
    logic             i_ready_q;
    logic             o_valid_q;

    logic [RW-1:0]    r_raw;
    logic [CW:0]      rem_d;
    logic [CW:0]      r_d;
    logic             scan_last_d;

    normshift_lsc #(.STEP(STEP), .RW(RW)) u_lsc (
        .top_i (work_q[WIDTH-1 -: STEP+1]),
        .r_o   (r_raw)
    );

    // Clamp so the total shift never exceeds WIDTH-1; that is what terminates the zero operand.
    always_comb begin
        rem_d       = (CW+1)'(WIDTH - 1) - {1'b0, cnt_q};
        r_d         = ((CW+1)'(r_raw) < rem_d) ? (CW+1)'(r_raw) : rem_d;
        scan_last_d = (r_d < (CW+1)'(STEP)) || (r_d == rem_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            zero_q    <= 1'b0;
            first_q   <= 1'b0;
            i_ready_q <= 1'b1;
            o_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (normshift_i_valid) begin
                        work_q    <= normshift_i;
                        cnt_q     <= '0;
                        zero_q    <= 1'b0;
                        first_q   <= 1'b1;
                        i_ready_q <= 1'b0;
                        state_q   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (first_q) begin
                        zero_q <= (work_q == '0);
                    end
                    first_q <= 1'b0;
                    work_q  <= work_q << r_d;
                    cnt_q   <= cnt_q + CW'(r_d);
                    if (scan_last_d) begin
                        o_valid_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (normshift_o_ready) begin
                        o_valid_q <= 1'b0;
                        i_ready_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    i_ready_q <= 1'b1;
                    o_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign normshift_i_ready = i_ready_q;
    assign normshift_o_valid = o_valid_q;
    assign normshift_o       = work_q;
    assign normshift_cnt     = cnt_q;
    assign normshift_zero    = zero_q;

endmodule
